// File: rtl/con_burst_reader.sv
// con_burst_reader: reads one burst of words from a FIFO, spacing the read strobes,
// and checks each captured word against an incrementing pattern while summing a checksum.
module con_burst_reader #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_MAX_BURST  = 1024,
    parameter int P_RD_IDLE    = 1,
    localparam int LW          = $clog2(P_MAX_BURST + 1)
) (
    input  logic                    CON_CLK,
    input  logic                    I_RST,
    input  logic                    I_START,
    input  logic [LW-1:0]           I_BURST_LEN,
    input  logic                    I_EMPTY,
    input  logic [P_DATA_WIDTH-1:0] I_RD_DATA,
    output logic                    O_RD_EN,
    output logic                    O_BUSY,
    output logic                    O_DONE,
    output logic [LW-1:0]           O_WORD_CNT,
    output logic [LW-1:0]           O_ERR_CNT,
    output logic [P_DATA_WIDTH-1:0] O_CHECKSUM
);
    localparam int DW       = P_DATA_WIDTH;
    localparam int GW       = (P_RD_IDLE > 1) ? $clog2(P_RD_IDLE) : 1;
    localparam int GAP_LAST = (P_RD_IDLE > 0) ? (P_RD_IDLE - 1) : 0;
    localparam logic [LW-1:0] MAX_LEN = LW'(P_MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   issued_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            cap_r;
    logic [LW-1:0]   word_cnt_r;
    logic [LW-1:0]   err_cnt_r;
    logic [DW-1:0]   checksum_r;

    logic            rd_en_s;
    logic            start_ok_s;
    logic            last_s;
    logic [LW-1:0]   len_clamp_s;
    logic [DW-1:0]   expected_s;

    assign len_clamp_s = (I_BURST_LEN > MAX_LEN) ? MAX_LEN : I_BURST_LEN;
    assign start_ok_s  = (state_r == ST_IDLE) && I_START;
    assign rd_en_s     = (state_r == ST_READ) && !I_EMPTY && !I_RST;
    assign last_s      = ((issued_r + LW'(1)) == len_r);
    // The pattern index is the number of words already captured in this burst.
    assign expected_s  = DW'(word_cnt_r) + DW'(1);

    assign O_RD_EN    = rd_en_s;
    assign O_BUSY     = (state_r != ST_IDLE);
    assign O_DONE     = (state_r == ST_DONE);
    assign O_WORD_CNT = word_cnt_r;
    assign O_ERR_CNT  = err_cnt_r;
    assign O_CHECKSUM = checksum_r;

    // Next-state decode for the burst sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (I_START) begin
                    if (len_clamp_s == {LW{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_en_s) begin
                    if (last_s) begin
                        state_next_s = ST_DRAIN;
                    end else if (P_RD_IDLE > 0) begin
                        state_next_s = ST_GAP;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GW'(GAP_LAST)) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_DRAIN: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CON_CLK) begin
        if (I_RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Burst bookkeeping and capture of the word returned after each strobe.
    always_ff @(posedge CON_CLK) begin
        if (I_RST) begin
            len_r      <= {LW{1'b0}};
            issued_r   <= {LW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            cap_r      <= 1'b0;
            word_cnt_r <= {LW{1'b0}};
            err_cnt_r  <= {LW{1'b0}};
            checksum_r <= {DW{1'b0}};
        end else begin
            cap_r <= rd_en_s;
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end else begin
                gap_cnt_r <= {GW{1'b0}};
            end
            if (start_ok_s) begin
                len_r      <= len_clamp_s;
                issued_r   <= {LW{1'b0}};
                word_cnt_r <= {LW{1'b0}};
                err_cnt_r  <= {LW{1'b0}};
                checksum_r <= {DW{1'b0}};
            end else begin
                if (rd_en_s) begin
                    issued_r <= issued_r + LW'(1);
                end
                // Capture is keyed only on the delayed strobe, so DRAIN needs no special case.
                if (cap_r) begin
                    word_cnt_r <= word_cnt_r + LW'(1);
                    checksum_r <= checksum_r + I_RD_DATA;
                    if (I_RD_DATA != expected_s) begin
                        err_cnt_r <= err_cnt_r + LW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_con_burst_reader.sv
// Directed bench for con_burst_reader: one instance with one idle cycle between reads,
// one with back-to-back reads for the full-length and clamped bursts.
module tb_con_burst_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, empty;
    logic [10:0] blen;
    logic [7:0]  rd_data;
    logic        rd_en, busy, done;
    logic [10:0] word_cnt, err_cnt;
    logic [7:0]  checksum;

    logic        z_rst, z_start, z_empty;
    logic [10:0] z_blen;
    logic [7:0]  z_rd_data;
    logic        z_rd_en, z_busy, z_done;
    logic [10:0] z_word_cnt, z_err_cnt;
    logic [7:0]  z_checksum;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_strobes, r_dones, r_bad_gap, r_stall_rd;
    logic        r_timeout;
    logic [10:0] r_wc, r_ec;
    logic [7:0]  r_cks;

    con_burst_reader #(.P_DATA_WIDTH(8), .P_MAX_BURST(1024), .P_RD_IDLE(1)) dut (
        .CON_CLK(clk), .I_RST(rst), .I_START(start), .I_BURST_LEN(blen),
        .I_EMPTY(empty), .I_RD_DATA(rd_data), .O_RD_EN(rd_en), .O_BUSY(busy),
        .O_DONE(done), .O_WORD_CNT(word_cnt), .O_ERR_CNT(err_cnt), .O_CHECKSUM(checksum)
    );

    con_burst_reader #(.P_DATA_WIDTH(8), .P_MAX_BURST(1024), .P_RD_IDLE(0)) dut0 (
        .CON_CLK(clk), .I_RST(z_rst), .I_START(z_start), .I_BURST_LEN(z_blen),
        .I_EMPTY(z_empty), .I_RD_DATA(z_rd_data), .O_RD_EN(z_rd_en), .O_BUSY(z_busy),
        .O_DONE(z_done), .O_WORD_CNT(z_word_cnt), .O_ERR_CNT(z_err_cnt), .O_CHECKSUM(z_checksum)
    );

    // Runs one burst on the paced instance, acting as the FIFO; results land in r_*.
    task automatic drive_burst(input int len, input int stall_len, input int bad_idx,
                               input logic [7:0] bad_val, input int busy_start_at);
        int   cap_k = 0;
        logic pend = 1'b0;
        int   stall_done = 0;
        int   last_strobe = -1;
        bit   got_done = 1'b0;
        r_strobes = 0; r_dones = 0; r_bad_gap = 0; r_stall_rd = 0;
        r_wc = 11'd0; r_ec = 11'd0; r_cks = 8'd0;
        @(negedge clk);
        start = 1'b1; blen = 11'(len); empty = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            @(negedge clk);
            start = (cyc == busy_start_at);
            if (start) blen = 11'd7;
            if (pend) begin
                rd_data = (cap_k == bad_idx) ? bad_val : 8'(cap_k + 1);
                cap_k++;
            end
            empty = (stall_len > 0) && (r_strobes >= 3) && (stall_done < stall_len);
            if (empty) stall_done++;
            #1;
            pend = rd_en;
            if (rd_en) begin
                if (empty) r_stall_rd++;
                if (stall_len == 0 && last_strobe >= 0 && (cyc - last_strobe) != 2) r_bad_gap++;
                last_strobe = cyc;
                r_strobes++;
            end
            if (done) begin
                r_dones++;
                r_wc = word_cnt; r_ec = err_cnt; r_cks = checksum;
                got_done = 1'b1;
            end
        end
        r_timeout = !got_done;
        start = 1'b0; empty = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; blen = 11'd4; empty = 1'b0; rd_data = 8'd0;
        z_rst = 1'b1; z_start = 1'b0; z_blen = 11'd0; z_empty = 1'b0; z_rd_data = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({word_cnt, err_cnt, checksum} !== 30'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", word_cnt, err_cnt, checksum); end
        n_checks++; if (z_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b2b: got %b expected 0", z_busy); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; z_rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        drive_burst(4, 0, -1, 8'd0, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", r_timeout); end
        n_checks++; if (r_strobes !== 4) begin n_fail++; $display("FAIL basic_strobes: got %0d expected 4", r_strobes); end
        n_checks++; if (r_bad_gap !== 0) begin n_fail++; $display("FAIL basic_spacing: got %0d bad gaps expected 0", r_bad_gap); end
        n_checks++; if (r_dones !== 1) begin n_fail++; $display("FAIL basic_dones: got %0d expected 1", r_dones); end
        n_checks++; if (r_wc !== 11'd4) begin n_fail++; $display("FAIL basic_word_cnt: got %0d expected 4", r_wc); end
        n_checks++; if (r_ec !== 11'd0) begin n_fail++; $display("FAIL basic_err_cnt: got %0d expected 0", r_ec); end
        n_checks++; if (r_cks !== 8'h0A) begin n_fail++; $display("FAIL basic_checksum: got %h expected 0a", r_cks); end
        @(negedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_hold();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (word_cnt !== 11'd4) begin n_fail++; $display("FAIL hold_word_cnt: got %0d expected 4", word_cnt); end
        n_checks++; if (checksum !== 8'h0A) begin n_fail++; $display("FAIL hold_checksum: got %h expected 0a", checksum); end
    endtask

    task automatic test_empty_stall();
        drive_burst(8, 5, -1, 8'd0, -1);
        n_checks++; if (r_stall_rd !== 0) begin n_fail++; $display("FAIL stall_rd_while_empty: got %0d expected 0", r_stall_rd); end
        n_checks++; if (r_strobes !== 8) begin n_fail++; $display("FAIL stall_strobes: got %0d expected 8", r_strobes); end
        n_checks++; if (r_wc !== 11'd8) begin n_fail++; $display("FAIL stall_word_cnt: got %0d expected 8", r_wc); end
        n_checks++; if (r_ec !== 11'd0) begin n_fail++; $display("FAIL stall_err_cnt: got %0d expected 0", r_ec); end
        n_checks++; if (r_cks !== 8'h24) begin n_fail++; $display("FAIL stall_checksum: got %h expected 24", r_cks); end
    endtask

    task automatic test_data_error();
        drive_burst(8, 0, 2, 8'hFF, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL error_timeout: got %b expected 0", r_timeout); end
        n_checks++; if (r_ec !== 11'd1) begin n_fail++; $display("FAIL error_err_cnt: got %0d expected 1", r_ec); end
        n_checks++; if (r_wc !== 11'd8) begin n_fail++; $display("FAIL error_word_cnt: got %0d expected 8", r_wc); end
        n_checks++; if (r_cks !== 8'h20) begin n_fail++; $display("FAIL error_checksum: got %h expected 20", r_cks); end
    endtask

    task automatic test_full_wrap();
        int lens [2] = '{1024, 1500};
        foreach (lens[i]) begin
            int   k = 0, strobes = 0, first = -1, last = -1, done_cyc = -1;
            logic pend = 1'b0;
            logic [10:0] wc = 11'd0, ec = 11'd0;
            logic [7:0]  cks = 8'd0;
            @(negedge clk);
            z_start = 1'b1; z_blen = 11'(lens[i]); z_empty = 1'b0;
            for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
                @(negedge clk);
                z_start = 1'b0;
                if (pend) begin z_rd_data = 8'(k + 1); k++; end
                #1;
                pend = z_rd_en;
                if (z_rd_en) begin
                    if (first < 0) first = cyc;
                    last = cyc;
                    strobes++;
                end
                if (z_done) begin
                    done_cyc = cyc; wc = z_word_cnt; ec = z_err_cnt; cks = z_checksum;
                end
            end
            n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL full_timeout len=%0d: no done expected done", lens[i]); end
            n_checks++; if (strobes !== 1024) begin n_fail++; $display("FAIL full_strobes len=%0d: got %0d expected 1024", lens[i], strobes); end
            n_checks++; if (last - first !== 1023) begin n_fail++; $display("FAIL full_back_to_back len=%0d: got span %0d expected 1023", lens[i], last - first); end
            n_checks++; if (done_cyc - last !== 2) begin n_fail++; $display("FAIL full_done_latency len=%0d: got %0d expected 2", lens[i], done_cyc - last); end
            n_checks++; if (wc !== 11'd1024) begin n_fail++; $display("FAIL full_word_cnt len=%0d: got %0d expected 1024", lens[i], wc); end
            n_checks++; if (ec !== 11'd0) begin n_fail++; $display("FAIL full_err_cnt len=%0d: got %0d expected 0", lens[i], ec); end
            n_checks++; if (cks !== 8'h00) begin n_fail++; $display("FAIL full_checksum len=%0d: got %h expected 00", lens[i], cks); end
        end
    endtask

    task automatic test_mid_reset();
        int   st = 0, k = 0, nd = 0;
        logic pend = 1'b0;
        @(negedge clk);
        start = 1'b1; blen = 11'd8; empty = 1'b0;
        for (int c = 0; c < 20 && st < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pend) begin rd_data = 8'(k + 1); k++; end
            #1;
            pend = rd_en;
            if (rd_en) st++;
        end
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL midrst_strobes_before: got %0d expected 3", st); end
        @(negedge clk);
        rd_data = 8'(k + 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en: got %b expected 0", rd_en); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if ({word_cnt, err_cnt, checksum} !== 30'd0) begin n_fail++; $display("FAIL midrst_counters: got %0d/%0d/%0d expected 0/0/0", word_cnt, err_cnt, checksum); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (done) nd++;
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", nd); end
        drive_burst(2, 0, -1, 8'd0, -1);
        n_checks++; if (r_wc !== 11'd2 || r_cks !== 8'h03) begin n_fail++; $display("FAIL midrst_next_burst: got wc=%0d cks=%h expected 2 03", r_wc, r_cks); end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start = 1'b1; blen = 11'd0;
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL zero_rd_en_idle: got %b expected 0", rd_en); end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL zero_rd_en: got %b expected 0", rd_en); end
        n_checks++; if ({word_cnt, err_cnt, checksum} !== 30'd0) begin n_fail++; $display("FAIL zero_counters: got %0d/%0d/%0d expected 0/0/0", word_cnt, err_cnt, checksum); end
        @(negedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_busy_start();
        drive_burst(4, 0, -1, 8'd0, 2);
        n_checks++; if (r_strobes !== 4) begin n_fail++; $display("FAIL busystart_strobes: got %0d expected 4", r_strobes); end
        n_checks++; if (r_wc !== 11'd4) begin n_fail++; $display("FAIL busystart_word_cnt: got %0d expected 4", r_wc); end
        n_checks++; if (r_cks !== 8'h0A) begin n_fail++; $display("FAIL busystart_checksum: got %h expected 0a", r_cks); end
        n_checks++; if (r_dones !== 1) begin n_fail++; $display("FAIL busystart_dones: got %0d expected 1", r_dones); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_empty_stall();
        test_data_error();
        test_full_wrap();
        test_mid_reset();
        test_zero_len();
        test_busy_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
